karatsuba_seq_mul: RTL and testbench

Sequential one-level Karatsuba multiplier that splits two N-bit operands into halves. It time-multiplexes a single external combinational (N/2)x(N/2) multiplier core, driving its operands and consuming its product. The core is the radix-4 approximate Booth multiplier, or an exact one. The block issues three sub-products (z0, z2, z1), applies carry correction for the 33-bit middle sums, and recombines them into a 2N-bit result. It sits directly around the multiplier core and turns it into a 64x64 multiply unit with a start/done handshake.

---
 rtl/karatsuba_seq_mul.sv | 138 +++++++++++++
 tb/tb_karatsuba_seq_mul.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/karatsuba_seq_mul.sv
// Sequential one-level Karatsuba multiplier. Time-multiplexes one external (N/2)x(N/2) core
// over three sub-products (z0, z2, z1) and recombines them into a 2N-bit product.
module karatsuba_seq_mul #(
    parameter int unsigned N = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    output logic             busy,
    output logic             done,
    output logic [2*N-1:0]   p,
    output logic [N/2-1:0]   mul_x,
    output logic [N/2-1:0]   mul_y,
    input  logic [N-1:0]     mul_p
);

    localparam int unsigned H    = N / 2;
    localparam int unsigned ZPad = 2 * N - (2 * H + 3);

    typedef enum logic [2:0] {
        StIdle,
        StM0,
        StM2,
        StM1,
        StCmb
    } state_e;

    state_e             state_q;
    logic [H-1:0]       a_lo_q, a_hi_q, b_lo_q, b_hi_q;
    logic [H-1:0]       sa_l_q, sb_l_q;
    logic               carry_a_q, carry_b_q;
    logic [2*H-1:0]     z0_q, z2_q;
    logic [2*H+2:0]     z1f_q;

    logic [H:0]         sum_a, sum_b, corr_sum;
    logic [2*H+2:0]     z1f_next;
    logic [2*N-1:0]     mid, p_next;

    always_comb begin
        sum_a = {1'b0, a[N-1:H]} + {1'b0, a[H-1:0]};
        sum_b = {1'b0, b[N-1:H]} + {1'b0, b[H-1:0]};

        // The core only sees the low H bits of each sum; fold the dropped carries back in.
        corr_sum = (carry_a_q ? {1'b0, sb_l_q} : '0) + (carry_b_q ? {1'b0, sa_l_q} : '0);
        z1f_next = {3'b000, mul_p}
                 + {2'b00, corr_sum, {H{1'b0}}}
                 + {2'b00, carry_a_q & carry_b_q, {(2 * H){1'b0}}};

        // Middle term may go negative with an approximate core; it simply wraps.
        mid    = {{ZPad{1'b0}}, z1f_q} - {{N{1'b0}}, z0_q} - {{N{1'b0}}, z2_q};
        p_next = {z2_q, {N{1'b0}}} + (mid << H) + {{N{1'b0}}, z0_q};
    end

    always_comb begin
        mul_x = '0;
        mul_y = '0;
        case (state_q)
            StM0: begin
                mul_x = a_lo_q;
                mul_y = b_lo_q;
            end
            StM2: begin
                mul_x = a_hi_q;
                mul_y = b_hi_q;
            end
            StM1: begin
                mul_x = sa_l_q;
                mul_y = sb_l_q;
            end
            default: begin
                mul_x = '0;
                mul_y = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            busy      <= 1'b0;
            done      <= 1'b0;
            p         <= '0;
            a_lo_q    <= '0;
            a_hi_q    <= '0;
            b_lo_q    <= '0;
            b_hi_q    <= '0;
            sa_l_q    <= '0;
            sb_l_q    <= '0;
            carry_a_q <= 1'b0;
            carry_b_q <= 1'b0;
            z0_q      <= '0;
            z2_q      <= '0;
            z1f_q     <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_lo_q    <= a[H-1:0];
                        a_hi_q    <= a[N-1:H];
                        b_lo_q    <= b[H-1:0];
                        b_hi_q    <= b[N-1:H];
                        sa_l_q    <= sum_a[H-1:0];
                        sb_l_q    <= sum_b[H-1:0];
                        carry_a_q <= sum_a[H];
                        carry_b_q <= sum_b[H];
                        busy      <= 1'b1;
                        state_q   <= StM0;
                    end
                end
                StM0: begin
                    z0_q    <= mul_p;
                    state_q <= StM2;
                end
                StM2: begin
                    z2_q    <= mul_p;
                    state_q <= StM1;
                end
                StM1: begin
                    z1f_q   <= z1f_next;
                    state_q <= StCmb;
                end
                StCmb: begin
                    p       <= p_next;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_karatsuba_seq_mul.sv
// Bench for karatsuba_seq_mul: exact and approximate 32x32 cores, an operation-level
// reference model checked every cycle, plus directed literal results.
module tb_karatsuba_seq_mul;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [63:0]    a, b;
    logic           busy, done;
    logic [127:0]   p;
    logic [31:0]    mul_x, mul_y;
    logic [63:0]    mul_p;
    bit             use_approx;

    int n_checks;
    int n_pass;
    int n_fail;

    karatsuba_seq_mul #(.N(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p),
        .mul_x (mul_x),
        .mul_y (mul_y),
        .mul_p (mul_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact core, or radix-4 Booth where the four lowest digits of magnitude 2 are
    // approximated as magnitude 1. Result wraps to 64 bits like the hardware core.
    function automatic logic [63:0] core(input logic [31:0] x, input logic [31:0] y,
                                         input bit apx);
        logic [34:0] ye;
        logic [2:0]  t;
        logic [63:0] acc, pp;
        int          d, mag;
        if (!apx) return {32'b0, x} * {32'b0, y};
        ye  = {2'b00, y, 1'b0};
        acc = '0;
        for (int i = 0; i < 17; i++) begin
            t = 3'(ye >> (2 * i));
            d = int'(t[0]) + int'(t[1]) - 2 * int'(t[2]);
            if (i < 4 && (d == 2 || d == -2)) d = d / 2;
            mag = (d < 0) ? -d : d;
            pp  = ({32'b0, x} * 64'(mag)) << (2 * i);
            acc = (d < 0) ? acc - pp : acc + pp;
        end
        return acc;
    endfunction

    assign mul_p = core(mul_x, mul_y, use_approx);

    // Reference product: plain multiplication for the exact core; for the approximate
    // core, the Karatsuba composition of whatever the core returns.
    function automatic logic [127:0] golden(input logic [63:0] ga, input logic [63:0] gb,
                                            input bit apx);
        logic [32:0]  sa, sb;
        logic [127:0] z0, z2, z1f, corr;
        if (!apx) return {64'b0, ga} * {64'b0, gb};
        sa   = {1'b0, ga[63:32]} + {1'b0, ga[31:0]};
        sb   = {1'b0, gb[63:32]} + {1'b0, gb[31:0]};
        z0   = {64'b0, core(ga[31:0], gb[31:0], apx)};
        z2   = {64'b0, core(ga[63:32], gb[63:32], apx)};
        corr = (sa[32] ? {96'b0, sb[31:0]} : 128'b0) + (sb[32] ? {96'b0, sa[31:0]} : 128'b0);
        z1f  = {64'b0, core(sa[31:0], sb[31:0], apx)} + (corr << 32)
             + ((sa[32] && sb[32]) ? (128'd1 << 64) : 128'd0);
        return (z2 << 64) + ((z1f - z0 - z2) << 32) + z0;
    endfunction

    function automatic logic [31:0] sched(input logic [2:0] ph, input logic [63:0] v);
        logic [32:0] s;
        s = {1'b0, v[63:32]} + {1'b0, v[31:0]};
        case (ph)
            3'd1:    return v[31:0];
            3'd2:    return v[63:32];
            3'd3:    return s[31:0];
            default: return 32'd0;
        endcase
    endfunction

    // Operation-level model: phase counts cycles since acceptance (0 = idle).
    logic [2:0]   m_phase;
    logic         m_busy, m_done;
    logic [127:0] m_p;
    logic [63:0]  m_a, m_b;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 3'd0;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_p     <= '0;
            m_a     <= '0;
            m_b     <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_phase == 3'd0) begin
                if (start) begin
                    m_a     <= a;
                    m_b     <= b;
                    m_phase <= 3'd1;
                    m_busy  <= 1'b1;
                end
            end else if (m_phase == 3'd4) begin
                m_phase <= 3'd0;
                m_busy  <= 1'b0;
                m_done  <= 1'b1;
                m_p     <= golden(m_a, m_b, use_approx);
            end else begin
                m_phase <= m_phase + 3'd1;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic compare_cycle();
        chk("busy", 128'(busy), 128'(m_busy));
        chk("done", 128'(done), 128'(m_done));
        chk("p", p, m_p);
        chk("mul_x", 128'(mul_x), 128'(sched(m_phase, m_a)));
        chk("mul_y", 128'(mul_y), 128'(sched(m_phase, m_b)));
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
    endtask

    task automatic drive(input logic s, input logic [63:0] va, input logic [63:0] vb);
        start = s;
        a     = va;
        b     = vb;
    endtask

    task automatic run_op(input logic [63:0] va, input logic [63:0] vb,
                          input logic [127:0] lit, input bit has_lit, input string nm);
        int lat;
        drive(1'b1, va, vb);
        lat = 0;
        do begin
            tick();
            lat++;
            start = 1'b0;
        end while (done !== 1'b1 && lat < 12);
        chk({nm, "_latency"}, 128'(lat), 128'd5);
        if (has_lit) chk(nm, p, lit);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dones, d1, d2;
        logic [127:0] p1, p2;
        n_checks   = 0;
        n_pass     = 0;
        n_fail     = 0;
        use_approx = 1'b0;
        rst_n      = 1'b0;
        drive(1'b0, 64'd0, 64'd0);

        chk("approx_core_pin", {64'b0, core(32'd3, 32'd2, 1'b1)}, 128'd9);
        chk("exact_core_pin", {64'b0, core(32'hFFFF_FFFF, 32'd2, 1'b0)}, 128'h1_FFFF_FFFE);

        tick();
        tick();
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_done", 128'(done), 128'd0);
        chk("reset_p", p, 128'd0);
        rst_n = 1'b1;
        tick();

        run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               128'hFFFFFFFFFFFFFFFE0000000000000001, 1'b1, "all_ones");
        run_op(64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF,
               128'h0000000000000000FFFFFFFF00000000, 1'b1, "shifted");
        run_op(64'd0, 64'h123, 128'd0, 1'b1, "zero");
        run_op(64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001,
               128'h00000000000000010000000200000001, 1'b1, "mid_term");

        // Abort in M2: outputs clear at once and no done follows.
        drive(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321);
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("midop_rst_busy", 128'(busy), 128'd0);
        chk("midop_rst_done", 128'(done), 128'd0);
        chk("midop_rst_p", p, 128'd0);
        tick();
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done === 1'b1) dones++;
        end
        chk("midop_rst_no_done", 128'(dones), 128'd0);

        // Starts while busy are ignored.
        drive(1'b1, 64'h0000_0001_0000_0001, 64'h0000_0001_0000_0001);
        dones = 0;
        d1    = 0;
        p1    = '0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (done === 1'b1) begin
                dones++;
                d1 = k;
                p1 = p;
            end
            if (k <= 4) drive(1'b1, 64'(k) * 64'h1111, 64'(k) * 64'h2222);
            else drive(1'b0, 64'd0, 64'd0);
        end
        chk("busy_start_ignored_dones", 128'(dones), 128'd1);
        chk("busy_start_ignored_lat", 128'(d1), 128'd5);
        chk("busy_start_ignored_p", p1, 128'h00000000000000010000000200000001);

        // Start held through the done cycle is taken right after it.
        drive(1'b1, 64'd2, 64'd3);
        dones = 0;
        d1    = 0;
        d2    = 0;
        p1    = '0;
        p2    = '0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (done === 1'b1) begin
                dones++;
                if (dones == 1) begin
                    d1 = k;
                    p1 = p;
                end else begin
                    d2 = k;
                    p2 = p;
                end
            end
            if (k >= 10) drive(1'b0, 64'd0, 64'd0);
            else drive(1'b1, 64'hFFFF_FFFF_0000_0000, 64'd2);
        end
        chk("held_start_dones", 128'(dones), 128'd2);
        chk("held_start_first_p", p1, 128'd6);
        chk("held_start_interval", 128'(d2 - d1), 128'd5);
        chk("held_start_second_p", p2, 128'h0000000000000001FFFFFFFE00000000);

        use_approx = 1'b1;
        tick();
        for (int i = 0; i < 1000; i++) begin
            run_op({$urandom, $urandom}, {$urandom, $urandom}, 128'd0, 1'b0, "approx");
        end
        drive(1'b0, 64'd0, 64'd0);
        tick();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
